// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor, one SEG-bit carry segment per stage.
// Optional signed saturation, global-stall valid/ready flow control, sideband tag.
module pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int SAT   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             saturated,
    output logic [TAG_W-1:0] tag_out
);

    localparam int NS = WIDTH / SEG;
    localparam int L  = NS - 1;
    localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] a_q [NS];
    logic [WIDTH-1:0] b_q [NS];
    logic [WIDTH-1:0] s_q [NS];
    logic             c_q [NS];
    logic             m_q [NS];
    logic             v_q [NS];
    logic [TAG_W-1:0] t_q [NS];

    logic [WIDTH-1:0] a_d [NS];
    logic [WIDTH-1:0] b_d [NS];
    logic [WIDTH-1:0] s_d [NS];
    logic             c_d [NS];
    logic             m_d [NS];

    logic             adv;
    logic             ovf_w;
    logic [WIDTH-1:0] res_w;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage k resolves only bits [k*SEG +: SEG]; m_d is the carry into the segment's top bit.
    always_comb begin : seg_add
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
        logic [WIDTH-1:0] sn;
        logic             cr;
        logic             mc;
        logic             g;
        logic             p;
        pa = '0;
        pb = '0;
        sn = '0;
        cr = 1'b0;
        mc = 1'b0;
        g  = 1'b0;
        p  = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (k == 0) begin
                pa = x;
                pb = sub ? ~y : y;
                sn = '0;
                cr = sub;
            end else begin
                pa = a_q[k-1];
                pb = b_q[k-1];
                sn = s_q[k-1];
                cr = c_q[k-1];
            end
            mc = 1'b0;
            for (int i = 0; i < SEG; i++) begin
                g = pa[k*SEG+i] & pb[k*SEG+i];
                p = pa[k*SEG+i] ^ pb[k*SEG+i];
                if (i == SEG - 1) mc = cr;
                sn[k*SEG+i] = p ^ cr;
                cr = g | (p & cr);
            end
            a_d[k] = pa;
            b_d[k] = pb;
            s_d[k] = sn;
            c_d[k] = cr;
            m_d[k] = mc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                m_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
                t_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < NS; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                m_q[k] <= m_d[k];
            end
            v_q[0] <= in_valid;
            t_q[0] <= tag_in;
            for (int k = 1; k < NS; k++) begin
                v_q[k] <= v_q[k-1];
                t_q[k] <= t_q[k-1];
            end
        end
    end

    // On overflow both effective operands share a sign, so B's MSB picks the clamp rail.
    assign ovf_w = c_q[L] ^ m_q[L];
    assign res_w = ((SAT != 0) && ovf_w) ?
                   (b_q[L][WIDTH-1] ? MINN : MAXP) : s_q[L];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            saturated <= 1'b0;
            tag_out   <= '0;
        end else if (adv) begin
            out_valid <= v_q[L];
            if (v_q[L]) begin
                sum       <= res_w;
                cout      <= c_q[L];
                overflow  <= ovf_w;
                saturated <= (SAT != 0) && ovf_w;
                tag_out   <= t_q[L];
            end
        end
    end

    always_ff @(posedge clk) begin
        assert (WIDTH % SEG == 0)
            else $error("pipe_addsub: WIDTH must be a multiple of SEG");
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: saturating and wrapping instances driven in parallel.
// Expected results come from integer arithmetic on the operands.
module tb_pipe_addsub;

    localparam int W  = 16;
    localparam int SG = 4;
    localparam int NS = W / SG;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic          sub = 1'b0;
    logic [TW-1:0] tag_in = '0;
    logic          out_ready = 1'b1;

    logic          in_ready, out_valid, cout, overflow, saturated;
    logic [W-1:0]  sum;
    logic [TW-1:0] tag_out;

    logic          w_in_ready, w_out_valid, w_cout, w_overflow, w_saturated;
    logic [W-1:0]  w_sum;
    logic [TW-1:0] w_tag_out;

    pipe_addsub #(.WIDTH(W), .SEG(SG), .SAT(1), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .sub(sub), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .overflow(overflow), .saturated(saturated), .tag_out(tag_out)
    );

    pipe_addsub #(.WIDTH(W), .SEG(SG), .SAT(0), .TAG_W(TW)) dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
        .x(x), .y(y), .sub(sub), .tag_in(tag_in),
        .out_valid(w_out_valid), .out_ready(out_ready), .sum(w_sum), .cout(w_cout),
        .overflow(w_overflow), .saturated(w_saturated), .tag_out(w_tag_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  s;
        logic [W-1:0]  w;
        logic          c;
        logic          o;
        logic          t;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sb, input logic [TW-1:0] tg);
        exp_t e;
        int sa, sbv, r, ua, ub;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        ua  = int'({16'h0, a});
        ub  = int'({16'h0, b});
        r   = sb ? sa - sbv : sa + sbv;
        e.w = r[W-1:0];
        e.o = (r > 32767) || (r < -32768);
        e.t = e.o;
        e.s = !e.o ? r[W-1:0] : (r > 0 ? 16'h7FFF : 16'h8000);
        e.c = sb ? (ua >= ub) : (ua + ub > 65535);
        e.tag = tg;
        return e;
    endfunction

    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_sum;
    logic [TW-1:0] prev_tag;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            chk("wrap_valid", w_out_valid, out_valid);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_sum", sum, prev_sum);
                chk("stall_tag", tag_out, prev_tag);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual_tag=%0d required=no_output", tag_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("tag", tag_out, e.tag);
                    chk("sum", sum, e.s);
                    chk("cout", cout, e.c);
                    chk("overflow", overflow, e.o);
                    chk("saturated", saturated, e.t);
                    chk("wrap_sum", w_sum, e.w);
                    chk("wrap_saturated", w_saturated, 0);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_tag   = tag_out;
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sb, input logic [TW-1:0] tg, input logic ordy,
                         output logic acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        x         = a;
        y         = b;
        sub       = sb;
        tag_in    = tg;
        out_ready = ordy;
        @(negedge clk);
        acc = v && in_ready;
    endtask

    task automatic send_dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                            input logic [TW-1:0] tg, input exp_t e);
        logic acc;
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            drive(1'b1, a, b, sb, tg, 1'b1, acc);
            n++;
        end
        if (acc) exp_q.push_back(e);
        else begin
            checks++;
            failures++;
            $display("FAIL send_timeout tag=%0d actual=not_accepted required=accepted", tg);
        end
    endtask

    task automatic drain();
        logic acc;
        int n;
        n = 0;
        while ((exp_q.size() > 0 || out_valid) && n < 60) begin
            drive(1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int n;
        logic inv [16];
        logic outv [16];
        logic [W-1:0] a, b;
        logic sb;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 0);
        chk("reset_flags", {cout, overflow, saturated}, 0);
        chk("reset_tag", tag_out, 0);
        chk("reset_in_ready", in_ready, 1);

        // full carry ripple and latency
        send_dir(16'hFFFF, 16'h0001, 1'b0, 4'd3,
                 exp_t'{s:16'h0000, w:16'h0000, c:1'b1, o:1'b0, t:1'b0, tag:4'd3});
        n = 0;
        do begin
            drive(1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
            n++;
        end while (!out_valid && n < 20);
        chk("latency", n - 1, NS);
        drain();

        send_dir(16'h7FFF, 16'h0001, 1'b0, 4'd4,
                 exp_t'{s:16'h7FFF, w:16'h8000, c:1'b0, o:1'b1, t:1'b1, tag:4'd4});
        send_dir(16'h0005, 16'h0007, 1'b1, 4'd5,
                 exp_t'{s:16'hFFFE, w:16'hFFFE, c:1'b0, o:1'b0, t:1'b0, tag:4'd5});
        send_dir(16'h8000, 16'h0001, 1'b1, 4'd6,
                 exp_t'{s:16'h8000, w:16'h7FFF, c:1'b1, o:1'b1, t:1'b1, tag:4'd6});
        send_dir(16'h8000, 16'h8000, 1'b0, 4'd7,
                 exp_t'{s:16'h8000, w:16'h0000, c:1'b1, o:1'b1, t:1'b1, tag:4'd7});
        send_dir(16'h0000, 16'h8000, 1'b1, 4'd8,
                 exp_t'{s:16'h7FFF, w:16'h8000, c:1'b0, o:1'b1, t:1'b1, tag:4'd8});
        drain();

        // backpressure: out_ready low for cycles 6..8 while the pipe is full
        begin
            int sent;
            logic ordy;
            sent = 0;
            for (int c = 0; c < 40 && (sent < 8 || exp_q.size() > 0); c++) begin
                ordy = !(c >= 6 && c < 9);
                a = W'($urandom);
                b = W'($urandom);
                sb = 1'($urandom);
                drive(sent < 8, a, b, sb, TW'(sent), ordy, acc);
                if (c < 12) chk("bp_in_ready", in_ready, ordy);
                if (acc) begin
                    exp_q.push_back(model(a, b, sb, TW'(sent)));
                    sent++;
                end
            end
            chk("bp_sent", sent, 8);
        end
        drain();

        // bubbles: alternating in_valid reappears NS+1 sample points later
        for (int c = 0; c < 16; c++) begin
            a = W'($urandom);
            b = W'($urandom);
            sb = 1'($urandom);
            drive(c < 8 && (c % 2 == 0), a, b, sb, TW'(c), 1'b1, acc);
            inv[c]  = acc;
            outv[c] = out_valid;
            if (acc) exp_q.push_back(model(a, b, sb, TW'(c)));
        end
        for (int c = 0; c < 16; c++) begin
            if (c < NS + 1) chk("bubble_lead", outv[c], 0);
            else chk("bubble_pattern", outv[c], inv[c-NS-1]);
        end
        drain();

        // reset with three operations in flight, head one stalled at the output
        for (int c = 0; c < 3; c++) begin
            a = W'($urandom);
            b = W'($urandom);
            drive(1'b1, a, b, 1'b0, TW'(c + 9), 1'b0, acc);
            if (acc) exp_q.push_back(model(a, b, 1'b0, TW'(c + 9)));
        end
        n = 0;
        while (!out_valid && n < 20) begin
            drive(1'b0, '0, '0, 1'b0, '0, 1'b0, acc);
            n++;
        end
        chk("rst_pre_valid", out_valid, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_sum", sum, 0);
        chk("rst_async_tag", tag_out, 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, '0, '0, 1'b0, '0, 1'b1, acc);
            chk("rst_no_stale", out_valid, 0);
        end
        send_dir(16'h1234, 16'h1111, 1'b1, 4'd2,
                 exp_t'{s:16'h0123, w:16'h0123, c:1'b1, o:1'b0, t:1'b0, tag:4'd2});
        drain();

        // random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            logic [TW-1:0] tg;
            a  = pick();
            b  = pick();
            sb = 1'($urandom);
            tg = TW'($urandom);
            drive($urandom_range(0, 9) < 7, a, b, sb, tg, $urandom_range(0, 3) != 0, acc);
            if (acc) exp_q.push_back(model(a, b, sb, tg));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined two's-complement adder/subtractor with optional signed saturation and valid/ready flow control. It is the successor to the single-cycle carry-lookahead adder and is used in the PE partial-sum path, where the accumulation width outgrows a single-cycle carry chain. The carry chain is split into `SEG`-bit segments, with one segment resolved per pipeline stage. An opaque tag travels alongside each operation.

## Interface
Parameters:
- `WIDTH`, 16: operand and result width in bits; must satisfy `WIDTH % SEG == 0`.
- `SEG`, 4: bits resolved per stage. Number of stages `NS = WIDTH/SEG`. Setting `SEG = WIDTH` gives a single-stage adder.
- `SAT`, 1: 1 = clamp the result on signed overflow; 0 = wrap.
- `TAG_W`, 4: sideband tag width; must be ≥ 1.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: an operation is offered on the input.
- `in_ready`, out, 1: the block accepts the offered operation this cycle.
- `x`, in, WIDTH: operand A.
- `y`, in, WIDTH: operand B.
- `sub`, in, 1: 0 = `x+y`; 1 = `x−y`, computed as `x + ~y + 1`.
- `tag_in`, in, TAG_W: sideband value, returned unchanged with the result.
- `out_valid`, out, 1: a result is presented.
- `out_ready`, in, 1: the consumer takes the result.
- `sum`, out, WIDTH: result, after saturation if enabled.
- `cout`, out, 1: raw carry out of the MSB. For subtraction, `cout = 1` means no borrow.
- `overflow`, out, 1: signed overflow of the unsaturated result.
- `saturated`, out, 1: the clamp was applied. Equals `SAT & overflow`.
- `tag_out`, out, TAG_W: tag belonging to the presented result.

## Operation
- Stage k (k = 0..NS−1) computes bits `[k*SEG +: SEG]`:
  - generate `g = a&b`, propagate `p = a^b`, ripple/lookahead carry within the segment;
  - carry into the segment is the registered carry from stage k−1;
  - carry into stage 0 is `sub`.
- Operand skew:
  - each stage register carries the not-yet-consumed upper operand bits, with `y` already inverted when `sub = 1`;
  - each stage register carries the already-computed lower sum bits;
  - each stage register carries `valid` and `tag`.
  - Each stage consumes only its own segment.
- The final stage forms:
  - `cout`: carry out of the MSB;
  - `overflow = c[WIDTH] ^ c[WIDTH−1]`, i.e. the carry into the MSB XOR the carry out;
  - if `SAT = 1` and `overflow = 1`: `sum = 0x7F..F` when the effective operand B MSB is 0, else `0x80..0`.
- Results are registered. `sum`, `cout`, `overflow`, `saturated`, `tag_out` are held stable while `out_valid & ~out_ready`.
- Flow control is a global stall:
  - `adv = ~out_valid | out_ready`;
  - all stages shift only when `adv = 1`;
  - `in_ready = adv`, combinational from `out_valid` and `out_ready`;
  - a transfer happens on `in_valid & in_ready`. When `in_valid = 0` while `adv = 1`, a bubble (valid = 0) enters stage 0.
- Ordering is strictly FIFO. Results are never dropped or duplicated.

## Timing
- Reset (asynchronous, immediate):
  - all stage valid bits = 0 and `out_valid = 0`;
  - `sum`, `cout`, `overflow`, `saturated`, `tag_out` = 0;
  - in-flight operations are discarded;
  - `in_ready = 1` from the first cycle after reset deasserts.
- Latency: an operation accepted at edge t gives `out_valid = 1` after edge t+NS, with no stalls in between.
- Throughput: one operation per cycle when `out_ready` is held at 1.
- Stall: while `out_valid = 1` and `out_ready = 0`:
  - every stage freezes, including bubbles;
  - `in_ready = 0`.
  - The cycle `out_ready` rises, the pipeline advances and `in_ready = 1` in that same cycle.
- Simultaneous output and input transfer in one cycle is allowed and is the normal steady state.
- Bubbles are not squeezed out during a stall. This is a deliberate simplicity tradeoff.
- A simulation assertion checks that `WIDTH % SEG != 0` never occurs.

## Test plan
Configuration for all cases: WIDTH=16, SEG=4, SAT=1, NS=4, `out_ready = 1` unless noted.
- Full carry propagation: `x=0xFFFF, y=0x0001, sub=0, tag=3` → 4 cycles later `sum=0x0000, cout=1, overflow=0, saturated=0, tag_out=3`.
- Positive overflow: `x=0x7FFF + y=0x0001` → `sum=0x7FFF, overflow=1, saturated=1, cout=0`. Same case with SAT=0 → `sum=0x8000`.
- Subtraction: `0x0005 − 0x0007` → `sum=0xFFFE, cout=0, overflow=0`. Then `0x8000 − 0x0001` → `sum=0x8000, overflow=1, saturated=1, cout=1`.
- Backpressure: 8 back-to-back operations with tags 0..7, and `out_ready` low for 3 cycles mid-stream → `in_ready` low in exactly those cycles; `tag_out` sequence is 0..7 with no gaps or repeats; outputs are stable while stalled.
- Bubbles: alternate `in_valid` 1/0 → `out_valid` pattern matches the input pattern, shifted by 4 cycles.
- Reset mid-flight: 3 operations in flight, assert `reset` for 1 cycle → `out_valid = 0` immediately and stays 0 until new input arrives; no stale results appear afterwards.
